// File: rtl/tm1638_xfer.sv
// tm1638_xfer: STB-framed multi-word serial transaction engine for TM1638-class controllers
module tm1638_xfer #(
  parameter int CLK_DIV  = 3,
  parameter int WORD_W   = 8,
  parameter int WAIT_CYC = 12,
  parameter int STB_GAP  = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_read,
  input  logic              in_last,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              stb,
  output logic              sclk,
  input  logic              dio_in,
  output logic              dio_out,
  output logic              dio_oe
);
  localparam int M1   = CLK_DIV > WAIT_CYC ? CLK_DIV : WAIT_CYC;
  localparam int CMAX = M1 > STB_GAP ? M1 : STB_GAP;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = WORD_W > 1 ? $clog2(WORD_W) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HOLD, S_TURN, S_SHIFT, S_END, S_GAP} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt, w_lim;
  logic [BW-1:0]     r_bit;
  logic              r_phase, r_read, r_last, r_out_valid;
  logic [WORD_W-1:0] r_data, r_out_data;
  logic              w_accept, w_cnt_done, w_bit_done;
  assign in_ready   = (r_state == S_IDLE || r_state == S_HOLD) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_lim      = r_state == S_TURN ? CW'(WAIT_CYC - 1) : r_state == S_GAP ? CW'(STB_GAP - 1) : CW'(CLK_DIV - 1);
  assign w_cnt_done = r_cnt == w_lim;
  assign w_bit_done = r_bit == BW'(WORD_W - 1);
  assign busy       = r_state != S_IDLE;
  assign stb        = r_state == S_IDLE || r_state == S_GAP;
  assign sclk       = !(r_state == S_SHIFT && !r_phase);
  assign dio_oe     = r_state == S_SHIFT && !r_read;
  assign dio_out    = dio_oe && r_data[0];
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  // next-state: a read following a write inserts the turnaround wait
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_SETUP : S_IDLE;
      S_SETUP: w_next = w_cnt_done ? S_SHIFT : S_SETUP;
      S_HOLD:  w_next = !w_accept ? S_HOLD : (in_read && !r_read) ? S_TURN : S_SHIFT;
      S_TURN:  w_next = w_cnt_done ? S_SHIFT : S_TURN;
      S_SHIFT: w_next = (w_cnt_done && r_phase && w_bit_done) ? (r_last ? S_END : S_HOLD) : S_SHIFT;
      S_END:   w_next = w_cnt_done ? S_GAP : S_END;
      S_GAP:   w_next = w_cnt_done ? S_IDLE : S_GAP;
      default: w_next = S_IDLE;
    endcase
  end
  // state, phase timing, word latch and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_phase     <= 1'b0;
      r_read      <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      r_cnt       <= (w_next != r_state || w_cnt_done || r_state == S_IDLE || r_state == S_HOLD) ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_data  <= in_data;
        r_read  <= in_read;
        r_last  <= in_last;
        r_bit   <= '0;
        r_phase <= 1'b0;
      end
      if (r_state == S_SHIFT && w_cnt_done) begin
        r_phase <= !r_phase;
        if (r_phase) begin
          r_data <= {r_read && dio_in, r_data[WORD_W-1:1]};
          r_bit  <= w_bit_done ? '0 : r_bit + 1'b1;
          if (w_bit_done && r_read) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {dio_in, r_data[WORD_W-1:1]};
          end
        end
      end
    end
  end
endmodule
